edge_detect_multi: RTL and testbench

Parametrised multi-channel edge detector, successor to the single-channel falling-edge detector. Per channel it provides:
- an input synchroniser;
- a glitch filter;
- a per-channel mode (rising / falling / both / off);
- a one-cycle event pulse, a sticky status bit and a saturating event counter.

It sits between asynchronous trigger sources (buttons, external strobes) and control FSMs or status registers.

---
 rtl/edge_detect_multi.sv | 139 +++++++++++++
 tb/tb_edge_detect_multi.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: multi-channel edge detector for asynchronous triggers.
// Each channel has a synchroniser, a glitch filter and a mode-qualified edge
// detector. The detector drives a one-cycle pulse, a sticky flag and a
// saturating event counter.
module edge_detect_multi #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     trigger,
  input  logic [2*NCH-1:0]   mode,
  input  logic [NCH-1:0]     sticky_clr,
  input  logic               cnt_clr,
  output logic [NCH-1:0]     edge_pulse,
  output logic [NCH-1:0]     edge_sticky,
  output logic [NCH*CNT_W-1:0] edge_count
);

  localparam int              FW      = $clog2(FILT_CYCLES) + 1;
  localparam logic [FW-1:0]    FC_LAST = FW'(FILT_CYCLES - 1);
  localparam logic [FW-1:0]    FC_ONE  = FW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_filt;
      logic [FW-1:0]          r_fcnt;
      logic                   r_pulse;
      logic                   r_sticky;
      logic [CNT_W-1:0]       r_cnt;

      logic                   w_sync;
      logic [1:0]             w_mode;
      logic                   w_accept;
      logic                   w_qual;
      logic                   w_filt_nxt;
      logic [FW-1:0]          w_fcnt_nxt;
      logic                   w_sticky_nxt;
      logic [CNT_W-1:0]       w_cnt_nxt;

      assign w_sync = r_sync[SYNC_STAGES-1];
      assign w_mode = mode[2*g+1 -: 2];

      // Synchroniser chain: the raw input feeds only the first stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], trigger[g]};
        end
      end

      // Glitch filter, edge qualification and next-state for pulse/sticky/count.
      always_comb begin
        w_accept     = 1'b0;
        w_filt_nxt   = r_filt;
        w_fcnt_nxt   = '0;
        w_qual       = 1'b0;
        w_sticky_nxt = r_sticky;
        w_cnt_nxt    = r_cnt;

        // A level change is accepted only after FILT_CYCLES consecutive
        // synced cycles that disagree with the filtered level.
        if (w_sync != r_filt) begin
          if (r_fcnt >= FC_LAST) begin
            w_accept   = 1'b1;
            w_filt_nxt = w_sync;
            w_fcnt_nxt = '0;
          end else begin
            w_fcnt_nxt = r_fcnt + FC_ONE;
          end
        end else begin
          w_fcnt_nxt = '0;
        end

        // The new level tells the polarity: 1 means rising, 0 means falling.
        case (w_mode)
          2'b01:   w_qual = w_accept & w_sync;
          2'b10:   w_qual = w_accept & ~w_sync;
          2'b11:   w_qual = w_accept;
          default: w_qual = 1'b0;
        endcase

        // Set wins over clear so that no event is lost.
        if (w_qual) begin
          w_sticky_nxt = 1'b1;
        end else if (sticky_clr[g]) begin
          w_sticky_nxt = 1'b0;
        end else begin
          w_sticky_nxt = r_sticky;
        end

        // A clear that coincides with an edge leaves the count at one.
        // Otherwise the count saturates.
        if (w_qual) begin
          if (cnt_clr) begin
            w_cnt_nxt = CNT_ONE;
          end else if (r_cnt == CNT_MAX) begin
            w_cnt_nxt = r_cnt;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else if (cnt_clr) begin
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end

      // Per-channel state: filtered level, filter counter and outputs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_filt   <= 1'b0;
          r_fcnt   <= '0;
          r_pulse  <= 1'b0;
          r_sticky <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_filt   <= w_filt_nxt;
          r_fcnt   <= w_fcnt_nxt;
          r_pulse  <= w_qual;
          r_sticky <= w_sticky_nxt;
          r_cnt    <= w_cnt_nxt;
        end
      end

      assign edge_pulse[g]                   = r_pulse;
      assign edge_sticky[g]                  = r_sticky;
      assign edge_count[CNT_W*g +: CNT_W]    = r_cnt;
    end
  endgenerate

endmodule

// File: tb/tb_edge_detect_multi.sv
// Testbench for edge_detect_multi.
// The bench runs directed scenarios and then a randomized phase. Each cycle it
// compares the DUT with a window-based reference model: a change is accepted
// when the last FILT synced samples all disagree with the filtered level.
module tb_edge_detect_multi;

  localparam int NCH   = 4;
  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       trigger;
  logic [2*NCH-1:0]     mode;
  logic [NCH-1:0]       sticky_clr;
  logic                 cnt_clr;
  logic [NCH-1:0]       edge_pulse;
  logic [NCH-1:0]       edge_sticky;
  logic [NCH*CNT_W-1:0] edge_count;

  edge_detect_multi #(
    .NCH(NCH), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .mode(mode),
    .sticky_clr(sticky_clr), .cnt_clr(cnt_clr), .edge_pulse(edge_pulse),
    .edge_sticky(edge_sticky), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [63:0]    m_samp [NCH];
  logic           m_filt [NCH];
  logic [NCH-1:0] m_pulse;
  logic [NCH-1:0] m_sticky;
  int             m_cnt  [NCH];
  int             tally  [NCH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_samp[ch] = '0;
      m_filt[ch] = 1'b0;
      m_cnt[ch]  = 0;
      tally[ch]  = 0;
    end
    m_pulse  = '0;
    m_sticky = '0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    for (int ch = 0; ch < NCH; ch++) begin
      logic [63:0] pre;
      logic        acc;
      logic        rise;
      logic        qual;
      logic [1:0]  m;
      pre  = m_samp[ch];
      acc  = 1'b1;
      for (int k = 0; k < FILT; k++) begin
        if (pre[SYNC-1+k] == m_filt[ch]) acc = 1'b0;
      end
      rise = ~m_filt[ch];
      if (acc) m_filt[ch] = ~m_filt[ch];
      m    = mode[2*ch +: 2];
      qual = acc && (m == 2'd3 || (m == 2'd1 && rise) || (m == 2'd2 && !rise));
      m_pulse[ch]  = qual;
      m_sticky[ch] = qual | (m_sticky[ch] & ~sticky_clr[ch]);
      if (qual) m_cnt[ch] = cnt_clr ? 1 : ((m_cnt[ch] < CMAX) ? m_cnt[ch] + 1 : CMAX);
      else if (cnt_clr) m_cnt[ch] = 0;
      m_samp[ch] = {pre[62:0], trigger[ch]};
    end
  endtask

  task automatic step();
    logic [NCH*CNT_W-1:0] ev;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    for (int ch = 0; ch < NCH; ch++) ev[CNT_W*ch +: CNT_W] = CNT_W'(m_cnt[ch]);
    chk("pulse", edge_pulse, m_pulse);
    chk("sticky", edge_sticky, m_sticky);
    chk("count", edge_count, ev);
    for (int ch = 0; ch < NCH; ch++) tally[ch] += int'(edge_pulse[ch]);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pulse", edge_pulse, 0);
    chk("rst_sticky", edge_sticky, 0);
    chk("rst_count", edge_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hold [NCH];
    rst_n      = 1'b0;
    trigger    = '0;
    mode       = '0;
    sticky_clr = '0;
    cnt_clr    = 1'b0;
    @(negedge clk);

    // 1: falling-only on ch0.
    mode = 8'b00_00_00_10;
    do_reset();
    trigger[0] = 1'b1; run(10);
    trigger[0] = 1'b0; run(4);
    chk("t1_no_early", tally[0], 0);
    run(1);
    chk("t1_pulse_at_5", edge_pulse[0], 1);
    run(5);
    chk("t1_tally", tally[0], 1);
    chk("t1_sticky", edge_sticky[0], 1);
    chk("t1_count", edge_count[7:0], 1);

    // 2: glitch rejection on ch1 in mode both.
    mode = 8'b00_00_11_00;
    do_reset();
    trigger[1] = 1'b1; run(2);
    trigger[1] = 1'b0; run(10);
    chk("t2_glitch_tally", tally[1], 0);
    chk("t2_glitch_count", edge_count[15:8], 0);
    trigger[1] = 1'b1; run(3);
    trigger[1] = 1'b0; run(12);
    chk("t2_tally", tally[1], 2);
    chk("t2_count", edge_count[15:8], 2);

    // 3: mode matrix with the same square wave on all channels.
    mode = 8'b11_10_01_00;
    do_reset();
    repeat (3) begin
      trigger = 4'hF; run(10);
      trigger = 4'h0; run(10);
    end
    run(6);
    chk("t3_counts", edge_count, 32'h06_03_03_00);
    chk("t3_tally0", tally[0], 0);
    chk("t3_tally3", tally[3], 6);

    // 4: sticky/count clear coinciding with an accepted edge, then saturation.
    mode = 8'b00_11_00_00;
    do_reset();
    trigger[2] = 1'b1; run(10);
    trigger[2] = 1'b0; run(4);
    sticky_clr[2] = 1'b1; cnt_clr = 1'b1;
    run(1);
    sticky_clr = '0; cnt_clr = 1'b0;
    chk("t4_race_pulse", edge_pulse[2], 1);
    chk("t4_race_sticky", edge_sticky[2], 1);
    chk("t4_race_count", edge_count[23:16], 1);
    sticky_clr[2] = 1'b1; run(1); sticky_clr = '0;
    chk("t4_sticky_clr", edge_sticky[2], 0);
    mode = 8'b00_00_00_11;
    for (int i = 0; i < 264; i++) begin
      trigger[0] = ~trigger[0];
      run(4);
    end
    run(6);
    chk("t4_saturate", edge_count[7:0], CMAX);

    // 5: reset while a change is partly filtered.
    mode = 8'hFF;
    trigger = '0;
    do_reset();
    trigger = 4'h1; run(4);
    trigger = 4'h0;
    do_reset();
    run(10);
    chk("t5_no_pulse", tally[0], 0);

    // 6: input held high through reset.
    trigger = 4'h8;
    mode = 8'b01_00_00_00;
    do_reset();
    run(4);
    chk("t6_no_early", tally[3], 0);
    run(1);
    chk("t6_pulse_at_5", edge_pulse[3], 1);
    run(5);
    chk("t6_tally", tally[3], 1);
    chk("t6_count", edge_count[31:24], 1);
    mode = 8'b10_00_00_00;
    do_reset();
    run(10);
    chk("t6_fall_mode", tally[3], 0);

    // Randomized phase.
    trigger = '0;
    mode = 8'hFF;
    do_reset();
    for (int ch = 0; ch < NCH; ch++) hold[ch] = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (hold[ch] == 0) begin
          trigger[ch] = ~trigger[ch];
          hold[ch] = int'($urandom_range(6, 1));
        end else begin
          hold[ch]--;
        end
        sticky_clr[ch] = ($urandom_range(7, 0) == 0);
      end
      if (c % 50 == 0) mode = 8'($urandom);
      cnt_clr = ($urandom_range(63, 0) == 0);
      if (c == 700) do_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
